capa_test_sequencer: RTL and testbench

CAPA_TEST_SEQUENCER -- requirements
Module: capa_test_sequencer

---
 rtl/capa_test_pkg.sv | 24 ++
 rtl/capa_edge_timer.sv | 44 ++++
 rtl/capa_test_sequencer.sv | 139 +++++++++++++
 tb/tb_capa_test_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/capa_test_pkg.sv
// Shared types and default constants for the capacitance test sequencer.
package capa_test_pkg;

  // Search controller states; IDLE is encoded as zero so a reset debug view reads 0.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_MEASURE = 3'd3,
    ST_DECIDE  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int DEF_CODE_W        = 8;
  localparam int DEF_CNT_W         = 16;
  localparam int DEF_TIMEOUT       = 4095;
  localparam int DEF_SETTLE_CYCLES = 16;

  // Larger of two integers, used to size the shared cycle counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/capa_edge_timer.sv
// Rising-edge detector plus saturating propagation-time counter.
// The count advances once per run cycle until the first rising edge of sig,
// then freezes; hit flags the cycle in which that edge is seen.
module capa_edge_timer
  import capa_test_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             run,
  input  logic             sig,
  output logic             hit,
  output logic             captured,
  output logic [CNT_W-1:0] count
);

  logic sig_q;

  // First rising edge of this measurement window, judged against last cycle's value.
  assign hit = run & ~captured & sig & ~sig_q;

  // Previous-cycle copy of the arrival signal for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  // Counter: cleared at launch, counts until the edge, saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      captured <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      captured <= 1'b0;
    end else if (run && !captured) begin
      if (hit)                           captured <= 1'b1;
      else if (count != {CNT_W{1'b1}})   count    <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/capa_test_sequencer.sv
// Successive-approximation search for the test-capacitance code whose
// propagation time just beats the circuit under test.
// Handshake: start is a one-cycle request honoured only while busy is low;
// fin_test is a one-cycle completion strobe, after which capa_result and
// timeout_err stay valid until the next accepted start.
module capa_test_sequencer
  import capa_test_pkg::*;
#(
  parameter int CODE_W        = DEF_CODE_W,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int TIMEOUT       = DEF_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              circuit_edge,
  input  logic              test_edge,
  output logic              stim,
  output logic [CODE_W-1:0] capa_test_code,
  output logic [CNT_W-1:0]  circuit_propagation_time,
  output logic [CNT_W-1:0]  test_propagation_time,
  output logic [CODE_W-1:0] capa_result,
  output logic              busy,
  output logic              fin_test,
  output logic              timeout_err,
  output state_t            dbg_state
);

  localparam int CW = $clog2(max_int(TIMEOUT, SETTLE_CYCLES) + 1);
  localparam int BW = $clog2(CODE_W + 1);

  state_t            state, state_next;
  logic [CW-1:0]     cyc_cnt;
  logic [BW-1:0]     bit_idx;
  logic [CNT_W-1:0]  c_count, t_count;
  logic              c_hit, t_hit, c_cap, t_cap;
  logic              both_done, last_settle, last_meas;
  logic [CODE_W-1:0] trial_bit;

  assign both_done   = (c_cap | c_hit) & (t_cap | t_hit);
  assign last_settle = (cyc_cnt == CW'(SETTLE_CYCLES - 1));
  assign last_meas   = (cyc_cnt == CW'(TIMEOUT - 1));
  assign trial_bit   = CODE_W'(1) << bit_idx;
  assign busy        = (state != ST_IDLE);
  assign fin_test    = (state == ST_DONE);
  assign dbg_state   = state;

  capa_edge_timer #(.CNT_W(CNT_W)) u_circuit_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_LAUNCH),
    .run      (state == ST_MEASURE),
    .sig      (circuit_edge),
    .hit      (c_hit),
    .captured (c_cap),
    .count    (c_count)
  );

  capa_edge_timer #(.CNT_W(CNT_W)) u_test_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state == ST_LAUNCH),
    .run      (state == ST_MEASURE),
    .sig      (test_edge),
    .hit      (t_hit),
    .captured (t_cap),
    .count    (t_count)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; an edge in the final measure cycle still counts toward DECIDE.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:    if (start) state_next = ST_SETTLE;
      ST_SETTLE:  if (last_settle) state_next = ST_LAUNCH;
      ST_LAUNCH:  state_next = ST_MEASURE;
      ST_MEASURE: begin
        if (both_done)      state_next = ST_DECIDE;
        else if (last_meas) state_next = ST_DONE;
      end
      ST_DECIDE:  state_next = (bit_idx == '0) ? ST_DONE : ST_SETTLE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Cycle counter for settle and measure windows, restarted on every state change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          cyc_cnt <= '0;
    else if (state_next != state)                     cyc_cnt <= '0;
    else if (state == ST_SETTLE || state == ST_MEASURE) cyc_cnt <= cyc_cnt + CW'(1);
  end

  // Search datapath: trial code, stimulus, result bits and captured times.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stim                     <= 1'b0;
      capa_test_code           <= '0;
      capa_result              <= '0;
      timeout_err              <= 1'b0;
      circuit_propagation_time <= '0;
      test_propagation_time    <= '0;
      bit_idx                  <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          capa_result <= '0;
          timeout_err <= 1'b0;
          bit_idx     <= BW'(CODE_W - 1);
        end
        ST_LAUNCH: begin
          capa_test_code <= capa_result | trial_bit;
          stim           <= 1'b1;
        end
        ST_MEASURE: if (!both_done && last_meas) begin
          timeout_err <= 1'b1;
          capa_result <= '0;
          stim        <= 1'b0;
        end
        ST_DECIDE: begin
          if (t_count < c_count) capa_result <= capa_test_code;
          circuit_propagation_time <= c_count;
          test_propagation_time    <= t_count;
          stim                     <= 1'b0;
          if (bit_idx != '0) bit_idx <= bit_idx - BW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_capa_test_sequencer.sv
// Bench for capa_test_sequencer: two instances (wide counters / long timeout,
// and narrow counters / short timeout), a behavioural search model feeding an
// expected queue, and a negedge monitor that checks every completed search.
module tb_capa_test_sequencer;
  import capa_test_pkg::*;

  localparam int NEVER = 1 << 30;

  typedef struct packed {
    logic [0:0]  inst;
    logic [7:0]  res;
    logic        to;
    logic [15:0] ct;
    logic [15:0] tt;
    logic [31:0] fin_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] start_v;
  logic [1:0] stim_v, busy_v, fin_v, to_v;
  logic [1:0][7:0]  code_v, res_v;
  logic [1:0][15:0] cpt_v, tpt_v;
  logic [1:0][2:0]  dbg_v;

  int dc_cfg [2];
  int sh_cfg [2];
  int ofs_cfg[2];
  int last_ct[2];
  int last_tt[2];

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   expired_cnt = 0;
  int   expired_seen = 0;
  logic [1:0] after_fin = 2'b00;

  // Clock and cycle index.
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int CWL = (g == 0) ? 16 : 5;
    logic           ce_l = 1'b0, te_l = 1'b0;
    logic           stim_l, busy_l, fin_l, to_l;
    logic [7:0]     code_l, res_l;
    logic [CWL-1:0] cpt_l, tpt_l;
    state_t         dbg_l;
    int             age = 0;

    capa_test_sequencer #(
      .CODE_W(8), .CNT_W(CWL),
      .TIMEOUT((g == 0) ? 400 : 50),
      .SETTLE_CYCLES((g == 0) ? 16 : 3)
    ) dut (
      .clk                      (clk),
      .rst                      (rst),
      .start                    (start_v[g]),
      .circuit_edge             (ce_l),
      .test_edge                (te_l),
      .stim                     (stim_l),
      .capa_test_code           (code_l),
      .circuit_propagation_time (cpt_l),
      .test_propagation_time    (tpt_l),
      .capa_result              (res_l),
      .busy                     (busy_l),
      .fin_test                 (fin_l),
      .timeout_err              (to_l),
      .dbg_state                (dbg_l)
    );

    assign stim_v[g] = stim_l;
    assign busy_v[g] = busy_l;
    assign fin_v[g]  = fin_l;
    assign to_v[g]   = to_l;
    assign code_v[g] = code_l;
    assign res_v[g]  = res_l;
    assign cpt_v[g]  = 16'(cpt_l);
    assign tpt_v[g]  = 16'(tpt_l);
    assign dbg_v[g]  = dbg_l;

    // Circuit model: each path rises a fixed number of cycles after stim rises.
    always @(negedge clk) begin
      if (stim_l) begin
        ce_l = (age >= dc_cfg[g]);
        te_l = (age >= (int'(code_l) >> sh_cfg[g]) + ofs_cfg[g]);
        age++;
      end else begin
        ce_l = 1'b0;
        te_l = 1'b0;
        age  = 0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: binary search decided by plain delay arithmetic.
  function automatic exp_t model(input int g, input int dc, input int sh, input int ofs, input int t0);
    int   s    = (g == 0) ? 16 : 3;
    int   tmo  = (g == 0) ? 400 : 50;
    int   sat  = (g == 0) ? 65535 : 31;
    int   res  = 0;
    int   lat  = 0;
    bit   stop = 0;
    exp_t e;
    e.to = 1'b0;
    for (int b = 7; b >= 0; b--) begin
      if (!stop) begin
        int trial, d_t, m, cc, tc;
        trial = res | (1 << b);
        d_t   = (trial >> sh) + ofs;
        m     = (dc > d_t) ? dc : d_t;
        if (m >= tmo) begin
          lat += s + 1 + tmo;
          res  = 0;
          e.to = 1'b1;
          stop = 1;
        end else begin
          lat += s + 1 + (m + 1) + 1;
          cc = (dc < sat) ? dc : sat;
          tc = (d_t < sat) ? d_t : sat;
          if (tc < cc) res = trial;
          last_ct[g] = cc;
          last_tt[g] = tc;
        end
      end
    end
    e.inst    = 1'(g);
    e.res     = 8'(res);
    e.ct      = 16'(last_ct[g]);
    e.tt      = 16'(last_tt[g]);
    e.fin_cyc = 32'(t0 + lat);
    return e;
  endfunction

  // Monitor: reset values, completed searches against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      for (int g = 0; g < 2; g++) begin
        chk("rst_stim",  longint'(stim_v[g]), 0);
        chk("rst_busy",  longint'(busy_v[g]), 0);
        chk("rst_fin",   longint'(fin_v[g]),  0);
        chk("rst_tmo",   longint'(to_v[g]),   0);
        chk("rst_code",  longint'(code_v[g]), 0);
        chk("rst_res",   longint'(res_v[g]),  0);
        chk("rst_ctime", longint'(cpt_v[g]),  0);
        chk("rst_ttime", longint'(tpt_v[g]),  0);
        chk("rst_state", longint'(dbg_v[g]),  0);
      end
      after_fin = 2'b00;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (after_fin[g]) begin
          chk("fin_one_cycle", longint'(fin_v[g]),  0);
          chk("idle_after",    longint'(busy_v[g]), 0);
          after_fin[g] = 1'b0;
        end
        if (fin_v[g]) begin
          chk("fin_expected", longint'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("instance",  longint'(g),          longint'(e.inst));
            chk("result",    longint'(res_v[g]),   longint'(e.res));
            chk("timeout",   longint'(to_v[g]),    longint'(e.to));
            chk("ctime",     longint'(cpt_v[g]),   longint'(e.ct));
            chk("ttime",     longint'(tpt_v[g]),   longint'(e.tt));
            chk("fin_cycle", longint'(cyc),        longint'(e.fin_cyc));
            chk("busy_done", longint'(busy_v[g]),  1);
            after_fin[g] = 1'b1;
          end
        end
      end
    end
    if (expired_cnt != expired_seen) begin
      chk("wait_bound", longint'(expired_cnt), longint'(expired_seen));
      expired_seen = expired_cnt;
    end
  end

  task automatic set_cfg(input int g, input int dc, input int sh, input int ofs);
    dc_cfg[g]  = dc;
    sh_cfg[g]  = sh;
    ofs_cfg[g] = ofs;
  endtask

  task automatic pulse_start(input int g, input bit expect_run);
    @(negedge clk);
    if (expect_run) exp_q.push_back(model(g, dc_cfg[g], sh_cfg[g], ofs_cfg[g], cyc + 1));
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 30000) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      expired_cnt++;
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic run_search(input int g, input int dc, input int sh, input int ofs);
    set_cfg(g, dc, sh, ofs);
    pulse_start(g, 1'b1);
    wait_drain();
  endtask

  // Stimulus sequence.
  initial begin
    rst     = 1'b1;
    start_v = 2'b00;
    for (int g = 0; g < 2; g++) begin
      set_cfg(g, NEVER, 0, 0);
      last_ct[g] = 0;
      last_tt[g] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_search(0, 100, 0, 0);     // result 99
    run_search(0, 300, 0, 0);     // result 255
    run_search(1, NEVER, 0, 0);   // timeout in first trial
    run_search(0, 40, 0, 0);      // trial 40 sees equal counts
    run_search(0, 41, 0, 0);      // last trial equal: counts 41/41, bit cleared
    run_search(1, 40, 2, 0);      // counters saturate at 31

    // Reset during the third trial, then a clean search.
    begin
      int   rises = 0;
      logic prev  = 1'b0;
      set_cfg(0, 100, 0, 0);
      pulse_start(0, 1'b0);
      for (int c = 0; c < 5000 && rises < 3; c++) begin
        @(negedge clk);
        if (stim_v[0] && !prev) rises++;
        prev = stim_v[0];
      end
      if (rises < 3) expired_cnt++;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      for (int g = 0; g < 2; g++) begin
        last_ct[g] = 0;
        last_tt[g] = 0;
      end
    end
    run_search(0, 100, 0, 0);

    // Start pulsed mid-search is ignored.
    set_cfg(0, 77, 0, 5);
    pulse_start(0, 1'b1);
    repeat (200) @(negedge clk);
    pulse_start(0, 1'b0);
    wait_drain();

    // Randomised searches on both instances.
    for (int i = 0; i < 8; i++) begin
      int g, dc;
      g  = int'($urandom_range(0, 1));
      dc = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, (g == 0) ? 450 : 60));
      run_search(g, dc, int'($urandom_range(0, 2)), int'($urandom_range(0, 20)));
    end

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
